qs1r_fir_decim: RTL and testbench

- Serial-MAC decimating FIR that consumes the 24-bit coefficient stream from the QS1R coefficient sequencer.
- Buffers incoming samples in a circular sample RAM. Every DECIM-th input it pulses the sequencer start, then multiply-accumulates TAPS products, one per clock.
- Emits one rounded output per run, with a strobe. Sits after the CIC stage and before the output packer.

---
 rtl/qs1r_fir_pkg.sv | 19 +
 rtl/qs1r_fir_decim_if.sv | 27 ++
 rtl/qs1r_fir_sample_ram.sv | 28 ++
 rtl/qs1r_fir_decim.sv | 173 +++++++++++++++++
 tb/tb_qs1r_fir_decim.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/qs1r_fir_pkg.sv
// Shared types and constants for the QS1R serial-MAC decimating FIR.
// Optional feature macro: QS1R_FIR_SATURATE_EN (clamp instead of wrap).
package qs1r_fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        MAC,
        ROUND,
        DONE
    } fir_state_e;

    localparam int COEFF_LATENCY = 3;
    localparam int RAM_LATENCY   = 2;

    localparam int DEF_TAPS  = 256;
    localparam int DEF_DECIM = 8;

endpackage

// File: rtl/qs1r_fir_decim_if.sv
// Sample stream in, filtered stream out, both strobe-qualified.
// Optional feature macro: QS1R_FIR_SATURATE_EN (no effect here).
interface qs1r_fir_decim_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 24
);

    logic                    in_strobe;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_strobe;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_strobe,
        output in_data,
        input  out_strobe,
        input  out_data
    );

    modport slave (
        input  in_strobe,
        input  in_data,
        output out_strobe,
        output out_data
    );

endinterface

// File: rtl/qs1r_fir_sample_ram.sv
// Circular sample store: one write port, one read port, 2-cycle read.
// Optional feature macro: QS1R_FIR_SATURATE_EN (no effect here).
module qs1r_fir_sample_ram #(
    parameter int DEPTH = 256,
    parameter int W     = 24,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clock,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [W-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [W-1:0] rd_data
);

    logic signed [W-1:0] mem [DEPTH];
    logic [AW-1:0]       rd_addr_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_addr_q <= rd_addr;
        rd_data   <= mem[rd_addr_q];
    end

endmodule

// File: rtl/qs1r_fir_decim.sv
// Serial-MAC decimating FIR fed by the QS1R coefficient sequencer.
// Optional feature macro: QS1R_FIR_SATURATE_EN (clamp instead of wrap).
module qs1r_fir_decim
    import qs1r_fir_pkg::*;
#(
    parameter int TAPS    = DEF_TAPS,
    parameter int DECIM   = DEF_DECIM,
    parameter int IN_W    = 24,
    parameter int COEFF_W = 24,
    parameter int ACC_W   = 56,
    parameter int OUT_W   = 24,
    parameter int SHIFT   = 23
) (
    input  logic                      clock,
    input  logic                      reset_n,
    qs1r_fir_decim_if.slave           bus,
    output logic                      coeff_start,
    input  logic signed [COEFF_W-1:0] coeff,
    output logic                      overrun
);

    localparam int AW      = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PW      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW      = $clog2(TAPS + 1);
    localparam int PROD_W  = IN_W + COEFF_W;
    localparam int SUM_W   = ACC_W + 1;
    localparam int RD_LEAD = COEFF_LATENCY - RAM_LATENCY;

    localparam logic signed [SUM_W-1:0] HALF =
        SUM_W'(1) << (SHIFT - 1);

    fir_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] phase;
    logic          run_req, launch, rd_step;
    logic          acc_en_q, acc_first_q;

    logic signed [IN_W-1:0]   sample;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q, prod_ext;
    logic signed [SUM_W-1:0]  biased;
    logic signed [OUT_W-1:0]  rnd_d, rnd_q;

    assign run_req = bus.in_strobe && (phase == PW'(DECIM - 1));

    qs1r_fir_sample_ram #(
        .DEPTH (TAPS),
        .W     (IN_W),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .we      (bus.in_strobe),
        .wr_addr (wr_ptr),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr),
        .rd_data (sample)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        launch  = 1'b0;
        rd_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (run_req) begin
                    launch  = 1'b1;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                rd_step = (cnt_q >= CW'(RD_LEAD));
                if (cnt_q == CW'(COEFF_LATENCY - 1)) begin
                    state_d = MAC;
                    cnt_d   = '0;
                end
            end
            MAC: begin
                rd_step = 1'b1;
                if (cnt_q == CW'(TAPS - 1)) begin
                    state_d = ROUND;
                    cnt_d   = '0;
                end
            end
            // Two cycles: drain product/acc pipe, then register rounding.
            ROUND: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            wr_ptr         <= '0;
            phase          <= '0;
            coeff_start    <= 1'b0;
            overrun        <= 1'b0;
            acc_en_q       <= 1'b0;
            acc_first_q    <= 1'b0;
            bus.out_strobe <= 1'b0;
            bus.out_data   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            coeff_start    <= launch;
            acc_en_q       <= (state_q == MAC);
            acc_first_q    <= (state_q == MAC) && (cnt_q == '0);
            bus.out_strobe <= (state_q == DONE);
            if (state_q == DONE) begin
                bus.out_data <= rnd_q;
            end
            if (run_req && state_q != IDLE) begin
                overrun <= 1'b1;
            end
            if (bus.in_strobe) begin
                wr_ptr <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
                phase  <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            end
        end
    end

    assign prod_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign biased   = SUM_W'(acc_q) + HALF;

    // Datapath: newest sample first, walking backwards through the ring.
    always_ff @(posedge clock) begin
        if (launch) begin
            rd_ptr <= wr_ptr;
        end else if (rd_step) begin
            rd_ptr <= (rd_ptr == '0) ? AW'(TAPS - 1) : rd_ptr - 1'b1;
        end
        prod_q <= PROD_W'(sample) * PROD_W'(coeff);
        if (acc_en_q) begin
            acc_q <= acc_first_q ? prod_ext : acc_q + prod_ext;
        end
        rnd_q <= rnd_d;
    end

`ifdef QS1R_FIR_SATURATE_EN
    localparam logic signed [SUM_W-1:0] OMAX =
        {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OMIN =
        {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [SUM_W-1:0] shifted;

    assign shifted = biased >>> SHIFT;

    always_comb begin
        rnd_d = shifted[OUT_W-1:0];
        if (shifted > OMAX) begin
            rnd_d = OMAX[OUT_W-1:0];
        end else if (shifted < OMIN) begin
            rnd_d = OMIN[OUT_W-1:0];
        end
    end
`else
    assign rnd_d = OUT_W'(biased >>> SHIFT);
`endif

endmodule

// File: tb/tb_qs1r_fir_decim.sv
// Directed bench for qs1r_fir_decim with a modelled coefficient sequencer.
// Optional feature macro: QS1R_FIR_SATURATE_EN (changes saturation expectation).
module tb_qs1r_fir_decim;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic coeff_start, overrun;
    logic signed [23:0] coeff;

    always #5 clock = ~clock;

    qs1r_fir_decim_if bus ();

    qs1r_fir_decim dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .coeff_start (coeff_start),
        .coeff       (coeff),
        .overrun     (overrun)
    );

    // Sequencer model: coeff[k] valid 3 cycles after coeff_start plus k.
    int cmode = 0;
    int seq_k = 1000;

    always @(posedge clock) begin
        if (coeff_start === 1'b1) seq_k <= -2;
        else seq_k <= seq_k + 1;
    end

    always_comb begin
        coeff = '0;
        case (cmode)
            0: coeff = 24'sd32768;
            1: coeff = 24'sd16384;
            2: coeff = 24'sd4194304;
            default: if (seq_k >= 0 && seq_k < 256) coeff = 24'(seq_k * 1024);
        endcase
    end

    int cyc = 0, cs_cyc = 0, os_cyc = 0, n_cs = 0, n_os = 0;
    logic signed [23:0] last_out = '0;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (coeff_start === 1'b1) begin
            cs_cyc <= cyc;
            n_cs   <= n_cs + 1;
        end
        if (bus.out_strobe === 1'b1) begin
            os_cyc   <= cyc;
            n_os     <= n_os + 1;
            last_out <= bus.out_data;
        end
    end

    int n_run = 0, n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic strobe(input logic signed [23:0] v, input int gap);
        bus.in_strobe = 1'b1;
        bus.in_data   = v;
        @(posedge clock); #1;
        bus.in_strobe = 1'b0;
        repeat (gap - 1) begin @(posedge clock); #1; end
    endtask

    task automatic wait_out(input int target, input string tag);
        int t = 0;
        while (n_os < target && t < 600) begin
            @(posedge clock); #1;
            t++;
        end
        check(tag, n_os, target);
    endtask

    typedef struct {
        int mode;
        int val;
        int gap;
        logic signed [23:0] exp;
    } vec_t;

    vec_t vecs[4];
    int os0, cs0;

    initial begin
        vecs[0] = '{mode: 0, val: 1000, gap: 40, exp: 24'sd1000};
        vecs[1] = '{mode: 1, val: 1001, gap: 34, exp: 24'sd501};
        vecs[2] = '{mode: 1, val: -1001, gap: 34, exp: -24'sd500};
`ifdef QS1R_FIR_SATURATE_EN
        vecs[3] = '{mode: 2, val: 8388607, gap: 34, exp: 24'sh7FFFFF};
`else
        vecs[3] = '{mode: 2, val: 8388607, gap: 34, exp: 24'shFFFF80};
`endif

        bus.in_strobe = 1'b0;
        bus.in_data   = '0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("rst_coeff_start", coeff_start, 0);
        check("rst_out_strobe", bus.out_strobe, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_overrun", overrun, 0);

        // Decimation phase: pulses on the 8th and 16th strobes only.
        cs0 = n_cs;
        os0 = n_os;
        repeat (7) strobe(1000, 40);
        check("phase_after7", n_cs - cs0, 0);
        strobe(1000, 40);
        check("phase_after8", n_cs - cs0, 1);
        repeat (8) strobe(1000, 40);
        check("phase_after16", n_cs - cs0, 2);
        wait_out(os0 + 2, "phase_outs");

        for (int i = 0; i < 4; i++) begin
            cmode = vecs[i].mode;
            os0 = n_os;
            repeat (264) strobe(24'(vecs[i].val), vecs[i].gap);
            wait_out(os0 + 33, $sformatf("vec%0d_outs", i));
            check($sformatf("vec%0d_data", i), last_out, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), os_cyc - cs_cyc, 262);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
        end

        // Impulse through a ramp coefficient set.
        cmode = 3;
        repeat (263) strobe(0, 34);
        os0 = n_os;
        strobe(24'sd8388607, 34);
        for (int j = 0; j < 4; j++) begin
            wait_out(os0 + 1 + j, $sformatf("imp%0d_outs", j));
            check($sformatf("imp%0d_data", j), last_out, j * 8192);
            if (j < 3) repeat (8) strobe(0, 34);
        end

        // Overrun: second request lands mid-MAC and is dropped.
        cmode = 0;
        os0 = n_os;
        cs0 = n_cs;
        repeat (16) strobe(1000, 10);
        repeat (400) begin @(posedge clock); #1; end
        check("ovr_outs", n_os - os0, 1);
        check("ovr_starts", n_cs - cs0, 1);
        check("ovr_flag", overrun, 1);

        // Refill with DC, then abort the last run at s+100.
        repeat (255) strobe(1000, 34);
        bus.in_strobe = 1'b1;
        bus.in_data   = 24'sd1000;
        @(posedge clock); #1;
        bus.in_strobe = 1'b0;
        check("abort_launch", coeff_start, 1);
        os0 = n_os;
        repeat (100) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("abort_coeff_start", coeff_start, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_overrun", overrun, 0);
        check("abort_out_strobe", bus.out_strobe, 0);
        reset_n = 1'b1;
        repeat (300) begin @(posedge clock); #1; end
        check("abort_no_out", n_os - os0, 0);
        os0 = n_os;
        repeat (8) strobe(1000, 34);
        wait_out(os0 + 1, "post_rst_outs");
        check("post_rst_data", last_out, 1000);
        check("post_rst_latency", os_cyc - cs_cyc, 262);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
